// File: rtl/cpp_internal_double_hyst_to_bool_array.sv
// Purpose: per-channel IEEE-754 double threshold compare with hysteresis and debounce -> registered bool.
// Latency: 1 clock from update_in_i strobe to out_o/update_out_o/edge_o.
// Backpressure: none; every strobed sample is consumed in the cycle it is presented.
module cpp_internal_double_hyst_to_bool_array #(
    parameter int          NCH      = 4,
    parameter logic [63:0] RISE_TH  = 64'hBFF0_0000_0000_0000,
    parameter logic [63:0] FALL_TH  = 64'h3FF0_0000_0000_0000,
    parameter int          DEBOUNCE = 1,
    parameter logic        INIT_OUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [64*NCH-1:0] in_i,
    input  logic [NCH-1:0]    update_in_i,
    output logic [NCH-1:0]    out_o,
    output logic [NCH-1:0]    update_out_o,
    output logic [NCH-1:0]    edge_o
);

    typedef enum logic {ST_LOW = 1'b0, ST_HIGH = 1'b1} state_e;

    // Map a double bit pattern onto an unsigned key whose ordering matches the
    // numeric ordering of all non-NaN values; -0.0 folds onto +0.0 so they tie.
    function automatic logic [63:0] order_key(input logic [63:0] b);
        logic [63:0] n;
        n = (b == 64'h8000_0000_0000_0000) ? 64'd0 : b;
        return n[63] ? ~n : {1'b1, n[62:0]};
    endfunction

    // Exponent all ones with a non-zero mantissa; the sign bit is irrelevant.
    function automatic logic is_nan(input logic [62:0] m);
        return (m[62:52] == 11'h7FF) && (m[51:0] != 52'd0);
    endfunction

    localparam logic [63:0] RISE_KEY = order_key(RISE_TH);
    localparam logic [63:0] FALL_KEY = order_key(FALL_TH);
    localparam logic [3:0]  DEB_CNT  = 4'(DEBOUNCE);
    localparam state_e      INIT_ST  = INIT_OUT ? ST_HIGH : ST_LOW;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [3:0]     cnt_q   [NCH];
    logic [3:0]     cnt_d   [NCH];
    logic [NCH-1:0] edge_q;
    logic [NCH-1:0] edge_d;
    logic [NCH-1:0] upd_q;
    logic [NCH-1:0] qual;

    // Per-channel qualification: the comparison direction depends on the current level.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [63:0] smp;
        logic [63:0] smp_key;
        assign smp      = in_i[64*g +: 64];
        assign smp_key  = order_key(smp);
        assign qual[g]  = !is_nan(smp[62:0]) &&
                          ((state_q[g] == ST_HIGH) ? (smp_key < FALL_KEY)
                                                   : (smp_key > RISE_KEY));
        assign out_o[g] = (state_q[g] == ST_HIGH);
    end

    // Next-state: unstrobed channels hold; a non-qualifying sample (incl. NaN) clears the streak.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            edge_d[i]  = 1'b0;
            if (update_in_i[i]) begin
                if (!qual[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] + 4'd1 == DEB_CNT) begin
                    state_d[i] = (state_q[i] == ST_HIGH) ? ST_LOW : ST_HIGH;
                    cnt_d[i]   = 4'd0;
                    edge_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // State, debounce counters and strobes; reset drops any partial streak immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= INIT_ST;
                cnt_q[i]   <= 4'd0;
            end
            edge_q <= '0;
            upd_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            edge_q <= edge_d;
            upd_q  <= update_in_i;
        end
    end

    assign update_out_o = upd_q;
    assign edge_o       = edge_q;

endmodule

// File: tb/tb_cpp_internal_double_hyst_to_bool_array.sv
// Purpose: scoreboard bench for the double hysteresis converter over four parameterisations.
// Latency: expects results one clock after each strobe, popped when update_out_o rises.
// Backpressure: none; stimulus never waits on the DUT.
module tb_cpp_internal_double_hyst_to_bool_array;

    localparam logic [63:0] P5     = 64'h4014_0000_0000_0000;
    localparam logic [63:0] P2     = 64'h4000_0000_0000_0000;
    localparam logic [63:0] P1_5   = 64'h3FF8_0000_0000_0000;
    localparam logic [63:0] P1     = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] P0_5   = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] PZ     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] NZ     = 64'h8000_0000_0000_0000;
    localparam logic [63:0] DENORM = 64'h0000_0000_0000_0001;
    localparam logic [63:0] M0_5   = 64'hBFE0_0000_0000_0000;
    localparam logic [63:0] M1     = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] M1_5   = 64'hBFF8_0000_0000_0000;
    localparam logic [63:0] M2     = 64'hC000_0000_0000_0000;
    localparam logic [63:0] PINF   = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] MINF   = 64'hFFF0_0000_0000_0000;
    localparam logic [63:0] NAN_P  = 64'h7FF8_0000_0000_0001;
    localparam logic [63:0] NAN_N  = 64'hFFF8_0000_0000_0001;

    typedef struct {
        int ch;
        bit o;
        bit e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] in_v  [4];
    logic [3:0]   upd_v [4];
    logic [3:0]   out_v [4];
    logic [3:0]   uo_v  [4];
    logic [3:0]   eo_v  [4];

    exp_t sbq [4][$];
    int   vectors = 0;
    int   errs    = 0;

    always #5 clk = ~clk;

    // d0: default overlapping bands; d1: classic +/-1; d2: classic with debounce 3; d3: zero thresholds
    cpp_internal_double_hyst_to_bool_array #(.NCH(4)) u_leg (
        .clk(clk), .rst_n(rst_n), .in_i(in_v[0]), .update_in_i(upd_v[0]),
        .out_o(out_v[0]), .update_out_o(uo_v[0]), .edge_o(eo_v[0]));

    cpp_internal_double_hyst_to_bool_array #(.NCH(4), .RISE_TH(P1), .FALL_TH(M1), .DEBOUNCE(1)) u_cls (
        .clk(clk), .rst_n(rst_n), .in_i(in_v[1]), .update_in_i(upd_v[1]),
        .out_o(out_v[1]), .update_out_o(uo_v[1]), .edge_o(eo_v[1]));

    cpp_internal_double_hyst_to_bool_array #(.NCH(4), .RISE_TH(P1), .FALL_TH(M1), .DEBOUNCE(3)) u_deb (
        .clk(clk), .rst_n(rst_n), .in_i(in_v[2]), .update_in_i(upd_v[2]),
        .out_o(out_v[2]), .update_out_o(uo_v[2]), .edge_o(eo_v[2]));

    cpp_internal_double_hyst_to_bool_array #(.NCH(4), .RISE_TH(PZ), .FALL_TH(PZ), .DEBOUNCE(1)) u_zero (
        .clk(clk), .rst_n(rst_n), .in_i(in_v[3]), .update_in_i(upd_v[3]),
        .out_o(out_v[3]), .update_out_o(uo_v[3]), .edge_o(eo_v[3]));

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input int ch, input logic [63:0] v, input bit eo, input bit ee);
        exp_t e;
        in_v[d][64*ch +: 64] = v;
        upd_v[d][ch]         = 1'b1;
        e.ch = ch;
        e.o  = eo;
        e.e  = ee;
        sbq[d].push_back(e);
    endtask

    // Clock the strobes in, then blank every input so unstrobed channels see X.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            upd_v[d] = '0;
            in_v[d]  = 'x;
        end
    endtask

    task automatic step(input int d, input int ch, input logic [63:0] v, input bit eo, input bit ee);
        drive(d, ch, v, eo, ee);
        tick();
    endtask

    // Monitor: every update_out bit pops the next expectation for that instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    vectors++;
                    if (uo_v[d][c] === 1'b1) begin
                        if (sbq[d].size() == 0) begin
                            errs++;
                            $display("FAIL unexpected_update d%0d ch%0d: update_out 1 required 0", d, c);
                        end else begin
                            e = sbq[d].pop_front();
                            if (e.ch != c || out_v[d][c] !== e.o || eo_v[d][c] !== e.e) begin
                                errs++;
                                $display("FAIL result d%0d ch%0d: out/edge got %b/%b required %b/%b (queued ch%0d)",
                                         d, c, out_v[d][c], eo_v[d][c], e.o, e.e, e.ch);
                            end
                        end
                    end else if (eo_v[d][c] !== 1'b0) begin
                        errs++;
                        $display("FAIL edge_without_update d%0d ch%0d: edge %b required 0", d, c, eo_v[d][c]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with every channel strobed at +5.0: nothing may leave reset.
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_v[d]  = {4{P5}};
            upd_v[d] = 4'hF;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_out d%0d", d), int'(out_v[d]), 0);
            check($sformatf("reset_upd d%0d", d), int'(uo_v[d]), 0);
            check($sformatf("reset_edge d%0d", d), int'(eo_v[d]), 0);
            upd_v[d] = '0;
        end
        #2;
        rst_n = 1'b1;

        // First sample after release: -0.5 > -1.0 flips ch0.
        step(0, 0, M0_5, 1'b1, 1'b1);

        // Overlapping bands: every in-band sample flips.
        step(0, 1, M2,  1'b0, 1'b0);
        step(0, 1, PZ,  1'b1, 1'b1);
        step(0, 1, PZ,  1'b0, 1'b1);
        step(0, 1, P2,  1'b1, 1'b1);
        step(0, 1, P0_5, 1'b0, 1'b1);

        // Classic hysteresis; equality with a threshold never flips.
        step(1, 0, P0_5, 1'b0, 1'b0);
        step(1, 0, P1,   1'b0, 1'b0);
        step(1, 0, P1_5, 1'b1, 1'b1);
        step(1, 0, PZ,   1'b1, 1'b0);
        step(1, 0, M1,   1'b1, 1'b0);
        step(1, 0, M1_5, 1'b0, 1'b1);

        // Debounce of 3 with idle gaps that must hold the count.
        step(2, 2, P2, 1'b0, 1'b0);
        step(2, 2, P2, 1'b0, 1'b0);
        step(2, 2, PZ, 1'b0, 1'b0);
        step(2, 2, P2, 1'b0, 1'b0);
        tick();
        step(2, 2, P2, 1'b0, 1'b0);
        tick();
        tick();
        step(2, 2, P2, 1'b1, 1'b1);

        // NaN breaks a streak; a fresh full streak is then needed.
        step(2, 3, P2,    1'b0, 1'b0);
        step(2, 3, P2,    1'b0, 1'b0);
        step(2, 3, NAN_P, 1'b0, 1'b0);
        step(2, 3, P2,    1'b0, 1'b0);
        step(2, 3, P2,    1'b0, 1'b0);
        step(2, 3, P2,    1'b1, 1'b1);

        // Negative NaN would order below +1.0 but must not pull ch0 low.
        step(0, 0, NAN_N, 1'b1, 1'b0);

        // Signed zero ties with a +0.0 threshold; +Inf and denormals compare normally.
        step(3, 0, NZ,     1'b0, 1'b0);
        step(3, 0, PINF,   1'b1, 1'b1);
        step(3, 1, PZ,     1'b0, 1'b0);
        step(3, 1, DENORM, 1'b1, 1'b1);
        step(3, 1, NZ,     1'b1, 1'b0);

        // All channels of one instance in the same cycle, then a partial mix.
        drive(0, 0, M2,   1'b0, 1'b1);
        drive(0, 1, PINF, 1'b1, 1'b1);
        drive(0, 2, M1,   1'b0, 1'b0);
        drive(0, 3, P0_5, 1'b1, 1'b1);
        tick();
        drive(0, 1, MINF, 1'b0, 1'b1);
        drive(0, 2, MINF, 1'b0, 1'b0);
        drive(1, 3, P5,   1'b1, 1'b1);
        tick();

        // Async reset mid-streak, between clock edges.
        step(2, 0, P2, 1'b0, 1'b0);
        step(2, 0, P2, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_out u_leg",  int'(out_v[0]), 0);
        check("async_out u_cls",  int'(out_v[1]), 0);
        check("async_out u_deb",  int'(out_v[2]), 0);
        check("async_upd u_deb",  int'(uo_v[2]),  0);
        #1;
        rst_n = 1'b1;
        step(2, 0, P2, 1'b0, 1'b0);
        step(2, 0, P2, 1'b0, 1'b0);
        step(2, 0, P2, 1'b1, 1'b1);

        // Drain: every queued expectation must have been consumed.
        repeat (3) tick();
        @(negedge clk);
        #1;
        for (int d = 0; d < 4; d++)
            check($sformatf("drain d%0d", d), sbq[d].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
